// File: rtl/alu_pc_core_pkg.sv
// Shared CPU datapath definitions: width, ALU opcodes and flag bit positions.
package cpu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/alu_pc_core_if.sv
// Bus between the register-file read muxes / sequencer and the datapath core.
interface alu_pc_core_if;
  import cpu_pkg::*;

  logic             pc_load;
  logic [WIDTH-1:0] pc_data;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] hi;
  logic             hi_valid;
  logic             alu_active;
  logic [2:0]       flags;

  modport master (
    output pc_load, pc_data, a, b, op,
    input  pc, pc_inc, alu_out, hi, hi_valid, alu_active, flags
  );

  modport slave (
    input  pc_load, pc_data, a, b, op,
    output pc, pc_inc, alu_out, hi, hi_valid, alu_active, flags
  );

endinterface

// File: rtl/alu_pc_core_adder16.sv
// Gate-level ripple-carry adder shared by the PC incrementer and the ALU.
module adder16
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = carry_in;

  // One full adder per bit, carry rippling from bit 0 upwards.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic half_s;
    assign half_s         = a[i] ^ b[i];
    assign sum[i]         = half_s ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & half_s);
  end

  assign carry_out = carry_s[WIDTH];

endmodule

// File: rtl/alu_pc_core.sv
// Datapath core: program counter register plus the combinational 16-bit ALU.
module alu_pc_core
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         clear,
  alu_pc_core_if.slave bus
);

  logic [WIDTH-1:0]   pc_r;
  logic [WIDTH-1:0]   pc_inc_s;
  logic               pc_carry_unused_s;

  logic [WIDTH-1:0]   add_b_s;
  logic               add_cin_s;
  logic [WIDTH-1:0]   add_sum_s;
  logic               add_cout_s;
  logic [2*WIDTH-1:0] product_s;

  logic [WIDTH-1:0]   out_s;
  logic [WIDTH-1:0]   hi_s;
  logic               carry_s;
  logic               ovf_s;
  logic               active_s;

  // PC incrementer; wrap from 0xFFFF to 0x0000 simply drops the carry.
  adder16 u_pc_adder (
    .a         (pc_r),
    .b         ({{(WIDTH-1){1'b0}}, 1'b1}),
    .carry_in  (1'b0),
    .sum       (pc_inc_s),
    .carry_out (pc_carry_unused_s)
  );

  // Program counter: clear beats load, load beats increment.
  always_ff @(posedge clk) begin
    if (clear) begin
      pc_r <= {WIDTH{1'b0}};
    end else if (bus.pc_load) begin
      pc_r <= bus.pc_data;
    end else begin
      pc_r <= pc_inc_s;
    end
  end

  // Subtraction reuses the adder as a + ~b + 1.
  always_comb begin
    add_b_s   = bus.b;
    add_cin_s = 1'b0;
    if (bus.op == OP_SUB) begin
      add_b_s   = ~bus.b;
      add_cin_s = 1'b1;
    end else begin
      add_b_s   = bus.b;
      add_cin_s = 1'b0;
    end
  end

  adder16 u_alu_adder (
    .a         (bus.a),
    .b         (add_b_s),
    .carry_in  (add_cin_s),
    .sum       (add_sum_s),
    .carry_out (add_cout_s)
  );

  assign product_s = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // Opcode decode: result, hi word, carry and overflow for each operation.
  always_comb begin
    out_s    = {WIDTH{1'b0}};
    hi_s     = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    active_s = 1'b1;
    case (bus.op)
      OP_ADD: begin
        out_s   = add_sum_s;
        carry_s = add_cout_s;
        ovf_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        out_s   = add_sum_s;
        carry_s = add_cout_s;
        ovf_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (add_sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL: begin
        out_s   = product_s[WIDTH-1:0];
        hi_s    = product_s[2*WIDTH-1:WIDTH];
        carry_s = (product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        ovf_s   = (product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
      end
      OP_AND: out_s = bus.a & bus.b;
      OP_OR:  out_s = bus.a | bus.b;
      OP_XOR: out_s = bus.a ^ bus.b;
      OP_DIV: begin
        if (bus.b == {WIDTH{1'b0}}) begin
          out_s   = {WIDTH{1'b1}};
          hi_s    = bus.a;
          carry_s = 1'b1;
        end else begin
          out_s   = bus.a / bus.b;
          hi_s    = bus.a % bus.b;
          carry_s = 1'b0;
        end
      end
      OP_SHL: out_s = bus.a << bus.b[3:0];
      OP_SHR: out_s = bus.a >> bus.b[3:0];
      default: active_s = 1'b0;
    endcase
  end

  assign bus.pc                 = pc_r;
  assign bus.pc_inc             = pc_inc_s;
  assign bus.alu_out            = out_s;
  assign bus.hi                 = hi_s;
  assign bus.alu_active         = active_s;
  assign bus.hi_valid           = active_s & bus.op[1] & bus.op[0];
  assign bus.flags[FLAG_Z]      = active_s && (out_s == {WIDTH{1'b0}});
  assign bus.flags[FLAG_C]      = carry_s;
  assign bus.flags[FLAG_V]      = ovf_s;

endmodule

// File: tb/tb_alu_pc_core.sv
// Self-checking bench for alu_pc_core: arithmetic reference model plus directed vectors.
module tb_alu_pc_core;

  logic clk;
  logic clear;
  int   total;
  int   bad;

  alu_pc_core_if bus ();

  alu_pc_core dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state for the program counter.
  int model_pc;
  bit model_valid;

  always @(posedge clk) begin
    if (clear) begin
      model_pc    <= 0;
      model_valid <= 1'b1;
    end else if (bus.pc_load) begin
      model_pc    <= int'(bus.pc_data);
    end else begin
      model_pc    <= (model_pc + 1) % 65536;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU reference from plain integer arithmetic.
  task automatic alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] o, output logic [15:0] h, output logic [2:0] f,
                           output logic act, output logic hv);
    int ua, ub, sa, sb, r, sr;
    longint p;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    o = 16'h0000; h = 16'h0000; c = 1'b0; v = 1'b0;
    act = (op >= 4'd1) && (op <= 4'd9);
    hv  = (op == 4'd3) || (op == 4'd7);
    case (op)
      4'd1: begin
        r = ua + ub; sr = sa + sb;
        o = r[15:0]; c = (r > 65535); v = (sr > 32767) || (sr < -32768);
      end
      4'd2: begin
        r = ua - ub; sr = sa - sb;
        o = r[15:0]; c = (ua >= ub); v = (sr > 32767) || (sr < -32768);
      end
      4'd3: begin
        p = longint'(ua) * longint'(ub);
        o = p[15:0]; h = p[31:16]; c = (p > 65535); v = c;
      end
      4'd4: o = a & b;
      4'd5: o = a | b;
      4'd6: o = a ^ b;
      4'd7: begin
        if (ub == 0) begin
          o = 16'hFFFF; h = a; c = 1'b1;
        end else begin
          r = ua / ub; o = r[15:0];
          r = ua % ub; h = r[15:0];
        end
      end
      4'd8: begin r = (ua * (1 << (ub % 16))) % 65536; o = r[15:0]; end
      4'd9: begin r = ua / (1 << (ub % 16)); o = r[15:0]; end
      default: ;
    endcase
    f = {v, c, act && (o == 16'h0000)};
  endtask

  // Every cycle: outputs against the model.
  always @(negedge clk) begin
    logic [15:0] mo, mh;
    logic [2:0]  mf;
    logic        ma, mhv;
    alu_model(bus.op, bus.a, bus.b, mo, mh, mf, ma, mhv);
    check("model alu_out", {16'h0000, bus.alu_out}, {16'h0000, mo});
    check("model hi", {16'h0000, bus.hi}, {16'h0000, mh});
    check("model flags", {29'h0, bus.flags}, {29'h0, mf});
    check("model active", {31'h0, bus.alu_active}, {31'h0, ma});
    check("model hi_valid", {31'h0, bus.hi_valid}, {31'h0, mhv});
    if (model_valid) begin
      check("model pc", {16'h0000, bus.pc}, model_pc);
      check("model pc_inc", {16'h0000, bus.pc_inc}, (model_pc + 1) % 65536);
    end
  end

  // One clock with the given PC controls, leaving outputs settled afterwards.
  task automatic cyc(input logic c, input logic l, input logic [15:0] d);
    clear       = c;
    bus.pc_load = l;
    bus.pc_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pc_exp(input string name, input logic [15:0] ep);
    check(name, {16'h0000, bus.pc}, {16'h0000, ep});
  endtask

  task automatic alu_vec(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eo, input logic [15:0] eh,
                         input logic [2:0] ef, input logic eact, input logic ehv);
    bus.op = op; bus.a = a; bus.b = b;
    #2;
    check({name, " out"}, {16'h0000, bus.alu_out}, {16'h0000, eo});
    check({name, " hi"}, {16'h0000, bus.hi}, {16'h0000, eh});
    check({name, " flags"}, {29'h0, bus.flags}, {29'h0, ef});
    check({name, " active"}, {31'h0, bus.alu_active}, {31'h0, eact});
    check({name, " hi_valid"}, {31'h0, bus.hi_valid}, {31'h0, ehv});
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    model_pc = 0; model_valid = 1'b0;
    clear = 1'b1; bus.pc_load = 1'b0; bus.pc_data = 16'h0000;
    bus.op = 4'd0; bus.a = 16'h0000; bus.b = 16'h0000;

    // Reset and increment
    cyc(1'b1, 1'b0, 16'h0000); pc_exp("reset pc", 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("inc1", 16'h0001);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("inc2", 16'h0002);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("inc3", 16'h0003);
    check("pc_inc after 3", {16'h0000, bus.pc_inc}, 32'h0000_0004);

    // Load, priority, wrap, mid-run clear
    cyc(1'b0, 1'b1, 16'h1234); pc_exp("load", 16'h1234);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("load+1", 16'h1235);
    cyc(1'b1, 1'b1, 16'h5555); pc_exp("clear beats load", 16'h0000);
    cyc(1'b0, 1'b1, 16'hFFFF); pc_exp("load ffff", 16'hFFFF);
    check("pc_inc wrap", {16'h0000, bus.pc_inc}, 32'h0000_0000);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("wrap", 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000); pc_exp("after wrap", 16'h0001);
    cyc(1'b1, 1'b0, 16'h0000); pc_exp("clear mid-run", 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);

    // ALU directed vectors            op     a         b         out       hi        {V,C,Z} act  hv
    alu_vec("add ovf",    4'd1,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 3'b100, 1'b1, 1'b0);
    alu_vec("add carry",  4'd1,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b011, 1'b1, 1'b0);
    alu_vec("sub borrow", 4'd2,  16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("sub equal",  4'd2,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b011, 1'b1, 1'b0);
    alu_vec("sub ovf",    4'd2,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 3'b110, 1'b1, 1'b0);
    alu_vec("mul",        4'd3,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 3'b110, 1'b1, 1'b1);
    alu_vec("mul small",  4'd3,  16'h0003, 16'h0005, 16'h000F, 16'h0000, 3'b000, 1'b1, 1'b1);
    alu_vec("div",        4'd7,  16'd100,  16'd7,    16'd14,   16'd2,    3'b000, 1'b1, 1'b1);
    alu_vec("div zero",   4'd7,  16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 3'b010, 1'b1, 1'b1);
    alu_vec("and",        4'd4,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("or",         4'd5,  16'hF0F0, 16'hFF00, 16'hFFF0, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("xor",        4'd6,  16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("and zero",   4'd4,  16'h00FF, 16'hFF00, 16'h0000, 16'h0000, 3'b001, 1'b1, 1'b0);
    alu_vec("shl",        4'd8,  16'h0001, 16'h000F, 16'h8000, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("shr",        4'd9,  16'h8000, 16'h0013, 16'h1000, 16'h0000, 3'b000, 1'b1, 1'b0);
    alu_vec("op0",        4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
    alu_vec("op12",       4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);
    alu_vec("op11",       4'd11, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0);

    // A few more model-checked cycles with varied operands while the PC runs
    for (int i = 0; i < 40; i++) begin
      bus.op = 4'(i % 16);
      bus.a  = 16'($urandom);
      bus.b  = (i % 5 == 0) ? 16'h0000 : 16'($urandom);
      cyc(1'b0, (i % 13 == 7) ? 1'b1 : 1'b0, 16'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pc_core.md
Name: alu_pc_core

Overview:
- Datapath core of the 16-bit CPU. Holds the program counter register, which increments every cycle or loads a jump/call target.
- Contains the combinational 16-bit ALU that computes register-to-register results, a hi word and flags.
- One shared 16-bit ripple adder design is used both for PC increment and for ALU add/sub.
- Sits between the register-file read muxes and the write-back bus.

Parameters:
- WIDTH, 16, datapath width of PC, operands and results. Only 16 is required to work.

Ports:
- clk  input  1  system clock; PC updates on the rising edge.
- clear  input  1  synchronous active-high reset.
- pc_load  input  1  load pc_data into PC at the next edge instead of incrementing.
- pc_data  input  16  jump/call target.
- pc  output  16  current program counter (registered).
- pc_inc  output  16  pc+1, combinational, wraps at 0xFFFF.
- a  input  16  ALU operand A (src1 register value).
- b  input  16  ALU operand B (src2 register value).
- op  input  4  instruction opcode (ins[15:12]).
- alu_out  output  16  ALU result, combinational.
- hi  output  16  upper or auxiliary result for mul/div, combinational.
- hi_valid  output  1  1 when op is 3 or 7.
- alu_active  output  1  1 when op is in 1..9.
- flags  output  3  [0]=zero, [1]=carry, [2]=signed overflow.

Behaviour:
- Program counter:
  - On posedge clk, priority is clear > pc_load > increment.
  - clear: pc<=0. pc_load: pc<=pc_data. Otherwise pc<=pc_inc.
  - After reset pc=0; first increment gives 1.
  - 0xFFFF increments to 0x0000, with no other effect.
  - clear and pc_load together: clear wins, pc=0.
  - clear asserted mid-run: pc=0 on that edge.
- pc_inc comes from an adder instance: A=pc, B=1, carry_in=0; carry out is ignored.
- ALU is purely combinational, zero latency, and has no state. Outputs are independent of clk/clear.
- ALU opcodes; unsigned unless stated:
  - 1 add: out=a+b via adder; carry=carry-out; ovf = (a15==b15) && (out15!=a15); hi=0.
  - 2 sub: out=a-b, computed as a+~b+1 on the same adder; carry=carry-out (1 = no borrow); ovf = (a15!=b15) && (out15!=a15); hi=0.
  - 3 mul: 32-bit product a*b; out=product[15:0], hi=product[31:16]; carry=ovf=(hi!=0).
  - 4 and, 5 or, 6 xor: bitwise; carry=ovf=0; hi=0.
  - 7 div: out=a/b, hi=a%b, carry=ovf=0. If b==0: out=0xFFFF, hi=a, carry=1.
  - 8 shl: out=a<<b[3:0], logical; carry=ovf=0; hi=0.
  - 9 shr: out=a>>b[3:0], logical, zero-fill; carry=ovf=0; hi=0.
  - 0, 10..15: alu_out=0, hi=0, flags=0, alu_active=0.
- zero flag = (alu_out==0) for ops 1..9; it is 0 for inactive ops.
- hi_valid = alu_active & op[1] & op[0].

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_DIV=7, OP_SHL=8, OP_SHR=9;
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_V=2;
  - WIDTH.
- One sub-module, adder16: inputs A, B, carry_in; outputs sum, carry_out; gate-level ripple-carry.
- Instantiate adder16 twice: once for PC increment, once for ALU add/sub. The ALU decode and PC register stay in the top module.

Test Plan:
- Reset/increment: clear=1 for 1 edge, then 3 edges with pc_load=0 → pc=0,1,2,3; pc_inc=4.
- Load and priority: pc_load=1, pc_data=0x1234 → pc=0x1234 next edge, then 0x1235. clear=1 and pc_load=1 together → pc=0. Load 0xFFFF, then one edge → pc=0x0000.
- Add/sub flags:
  - op=1, a=0x7FFF, b=1 → out=0x8000, V=1, C=0, Z=0.
  - op=1, a=0xFFFF, b=1 → out=0, C=1, Z=1.
  - op=2, a=5, b=7 → out=0xFFFE, C=0.
- Mul/div:
  - op=3, a=0x1234, b=0x0100 → out=0x3400, hi=0x0012, C=1, hi_valid=1.
  - op=7, a=100, b=7 → out=14, hi=2.
  - op=7, b=0 → out=0xFFFF, hi=a, C=1.
- Logic/shift: op=4/5/6 with a=0xF0F0, b=0xFF00 → 0xF000/0xFFF0/0x0FF0. op=8, a=1, b=15 → 0x8000. op=9, a=0x8000, b=0x13 → 0x1000 (only b[3:0] used).
- Inactive op: op=0 and op=12 with a=b=0xFFFF → alu_out=0, hi=0, flags=0, alu_active=0.
